// File: rtl/instr_fetch_decode_pkg.sv
// Shared opcodes, instruction-word field positions and FSM encoding for the
// fetch/decode stage.
package fetch_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int DST_MSB = 27;
  localparam int DST_LSB = 25;
  localparam int SRC_MSB = 24;
  localparam int SRC_LSB = 22;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  dest_reg;
    logic [2:0]  src_reg;
    logic [15:0] immediate;
  } fields_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_decoder.sv
// Combinational field extraction and opcode legality check.
// JMP (0101) is legal only when FETCH_JUMP_EN is defined.
module instr_decoder
  import fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  output fields_t     fields_o,
  output logic        legal_o,
  output logic        jump_o
);

  logic [3:0] op;
  logic       unused_reserved;

  // Bits [21:16] are reserved and deliberately ignored.
  assign unused_reserved = ^instr_i[21:16];

  always_comb begin
    op                 = instr_i[OPC_MSB:OPC_LSB];
    fields_o.opcode    = op;
    fields_o.dest_reg  = instr_i[DST_MSB:DST_LSB];
    fields_o.src_reg   = instr_i[SRC_MSB:SRC_LSB];
    fields_o.immediate = instr_i[IMM_MSB:IMM_LSB];
    legal_o            = 1'b0;
    jump_o             = 1'b0;
    case (op)
      OP_NOP, OP_LOAD, OP_MOV, OP_ADD, OP_XOR, OP_HALT: legal_o = 1'b1;
`ifdef FETCH_JUMP_EN
      OP_JMP: begin
        legal_o = 1'b1;
        jump_o  = 1'b1;
      end
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: fetches 32-bit words, presents each decoded
// instruction for one clock. Optional JMP support via FETCH_JUMP_EN.
module instr_fetch_decode
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  output logic [3:0]        opcode,
  output logic [2:0]        src_reg,
  output logic [2:0]        dest_reg,
  output logic [15:0]       immediate,
  output logic              instr_valid,
  output logic              halted,
  output logic              illegal_instr,
  output logic [15:0]       instr_count,
  output logic [1:0]        fsm_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic [15:0]       count_q, count_d;

  fields_t dec_fields;
  logic    dec_legal;
  logic    dec_jump;
  logic    fire;

  instr_decoder u_decoder (
    .instr_i  (ir_q),
    .fields_o (dec_fields),
    .legal_o  (dec_legal),
    .jump_o   (dec_jump)
  );

  // Memory handshake: imem_req stays high with a stable imem_addr until a
  // cycle in which imem_rvalid=1; imem_rvalid while imem_req=0 is ignored.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    imem_req  = 1'b0;
    fire      = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          state_d = is_halt(imem_rdata) ? ST_HALTED : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          fire    = 1'b1;
          pc_d    = dec_jump ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
          state_d = ST_REQ;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (!dec_legal) illegal_d = 1'b1;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Illegal and JMP words reach the datapath as NOP but still count as issued.
  always_comb begin
    opcode      = '0;
    src_reg     = '0;
    dest_reg    = '0;
    immediate   = '0;
    instr_valid = fire;
    if (fire && dec_legal && !dec_jump) begin
      opcode    = dec_fields.opcode;
      src_reg   = dec_fields.src_reg;
      dest_reg  = dec_fields.dest_reg;
      immediate = dec_fields.immediate;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign illegal_instr = illegal_q;
  assign instr_count   = count_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed programs plus random
// programs, checked against a program-walk reference model.
module tb_instr_fetch_decode;

`ifdef FETCH_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [3:0]  opcode;
  logic [2:0]  src_reg, dest_reg;
  logic [15:0] immediate;
  logic        instr_valid, halted, illegal_instr;
  logic [15:0] instr_count;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_W(8), .RESET_PC(8'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_rvalid   (imem_rvalid),
    .opcode        (opcode),
    .src_reg       (src_reg),
    .dest_reg      (dest_reg),
    .immediate     (immediate),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .illegal_instr (illegal_instr),
    .instr_count   (instr_count),
    .fsm_state     (fsm_state)
  );

  // ---------------- bench state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [256];
  logic [26:0] exp_q [$];   // {illegal, opcode, dest, src, imm} per issued instruction
  int          fa_q [$];    // expected fetch addresses, in order
  bit          exp_halt;
  int          halt_pc;
  int          n_issue;
  int          cnt_model;
  bit          ill_model;
  int          stall_pct, max_lat;
  int          wait_cnt, lat, req_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: walk the program ----------------
  function automatic void build_model(input int cap);
    int          pc;
    logic [31:0] w;
    logic [3:0]  op;
    bit          legal, jmp;
    exp_q.delete();
    fa_q.delete();
    exp_halt = 1'b0;
    halt_pc  = 0;
    n_issue  = 0;
    pc       = 0;
    for (int s = 0; s < cap; s++) begin
      w = mem[pc];
      fa_q.push_back(pc);
      op = w[31:28];
      if (op == 4'hF) begin
        exp_halt = 1'b1;
        halt_pc  = pc;
        break;
      end
      jmp   = JUMP_EN && (op == 4'h5);
      legal = (op <= 4'h4) || jmp;
      if (legal && !jmp) exp_q.push_back({1'b0, op, w[27:25], w[24:22], w[15:0]});
      else               exp_q.push_back({!legal, 26'h0});
      n_issue++;
      pc = jmp ? int'(w[7:0]) : (pc + 1) % 256;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic st);
    logic [26:0] e;
    @(negedge clk);
    start = st;
    stall = ($urandom_range(0, 99) < stall_pct);
    if (imem_req === 1'b1) begin
      if (wait_cnt == 0) begin
        lat      = $urandom_range(0, max_lat);
        req_addr = int'(imem_addr);
        chk("fetch_addr", imem_addr, (fa_q.size() != 0) ? 64'(fa_q.pop_front()) : 64'hDEAD_0000);
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      imem_rvalid = (wait_cnt == lat);
      imem_rdata  = imem_rvalid ? mem[imem_addr] : $urandom;
      wait_cnt++;
    end else begin
      wait_cnt    = 0;
      imem_rvalid = ($urandom_range(0, 3) == 0);
      imem_rdata  = $urandom;
    end
    #1;
    chk("illegal_flag", illegal_instr, ill_model);
    chk("instr_count", instr_count, cnt_model);
    if (instr_valid === 1'b1) begin
      chk("issue_expected", instr_valid, exp_q.size() != 0);
      chk("issue_not_stalled", stall, 1'b0);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h3FF_FFFF;
      chk("issue_fields", {opcode, dest_reg, src_reg, immediate}, e[25:0]);
      if (e[26]) ill_model = 1'b1;
      cnt_model++;
    end else begin
      chk("nop_fields", {instr_valid, opcode, dest_reg, src_reg, immediate}, 27'h0);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    fa_q.delete();
    exp_halt  = 1'b0;
    cnt_model = 0;
    ill_model = 1'b0;
    wait_cnt  = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_state", fsm_state, 2'd0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'd0);
    chk("rst_count", instr_count, 16'd0);
    chk("rst_illegal", illegal_instr, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_outputs", {instr_valid, opcode, dest_reg, src_reg, immediate}, 27'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    start       = 1'b0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;
    clear_model();
  endtask

  task automatic run_prog(input bit do_start, output int cycles);
    cycles = 0;
    if (do_start) tick(1'b1);
    while (halted !== 1'b1 && !(!exp_halt && exp_q.size() == 0) && cycles < 5000) begin
      tick(1'b0);
      cycles++;
    end
    chk("run_bounded", cycles < 5000, 1'b1);
    chk("issue_q_drained", exp_q.size(), 0);
    if (exp_halt) begin
      chk("halted", halted, 1'b1);
      chk("halt_state", fsm_state, 2'd3);
      chk("halt_pc", imem_addr, halt_pc);
      chk("halt_count", instr_count, n_issue);
      chk("halt_no_req", imem_req, 1'b0);
      chk("fetch_q_drained", fa_q.size(), 0);
    end else begin
      chk("not_halted", halted, 1'b0);
    end
  endtask

  task automatic zero_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic load_prog1();
    zero_mem();
    mem[0] = 32'h120000FF;
    mem[1] = 32'h24400000;
    mem[2] = 32'h34400000;
    mem[3] = 32'h44400000;
    mem[4] = 32'hF0000000;
  endtask

  task automatic gen_random_prog();
    for (int i = 0; i < 256; i++) begin
      int         r;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (r < 3)       op = 4'hF;
      else if (r < 10) op = 4'h5;
      else if (r < 16) op = 4'($urandom_range(6, 14));
      else             op = 4'($urandom_range(0, 4));
      mem[i] = {op, 28'($urandom)};
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cycles, guard;
    reset       = 1'b0;
    start       = 1'b0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    stall_pct   = 0;
    max_lat     = 0;
    clear_model();

    // Reset state and the example program with zero-wait memory.
    do_reset();
    load_prog1();
    build_model(64);
    run_prog(1'b1, cycles);
    chk("zero_wait_cycles", cycles, 10);

    // HALTED ignores start.
    tick(1'b1);
    tick(1'b0);
    chk("halt_sticky", {halted, fsm_state}, 3'b111);

    // Four stalled cycles in ISSUE, then a single issue.
    do_reset();
    build_model(64);
    tick(1'b1);
    tick(1'b0);
    stall_pct = 100;
    repeat (4) tick(1'b0);
    chk("stall_holds_issue", fsm_state, 2'd2);
    stall_pct = 0;
    run_prog(1'b0, cycles);

    // Variable memory latency, no stall.
    do_reset();
    max_lat = 3;
    build_model(64);
    run_prog(1'b1, cycles);

    // Illegal word at the top address, then pc wraps to 0.
    do_reset();
    max_lat = 0;
    zero_mem();
    mem[255] = 32'h70000000;
    build_model(258);
    run_prog(1'b1, cycles);
    chk("illegal_sticky", illegal_instr, 1'b1);

    // JMP word: legal jump to 2 when enabled, illegal otherwise.
    do_reset();
    zero_mem();
    mem[0] = 32'h50000002;
    mem[1] = 32'hF0000000;
    mem[2] = 32'h1A000123;
    mem[3] = 32'hF0000000;
    build_model(16);
    run_prog(1'b1, cycles);
    chk("jmp_illegal_flag", illegal_instr, !JUMP_EN);

    // Reset mid-REQ with rvalid in the same cycle: the word is discarded.
    do_reset();
    zero_mem();
    mem[1]  = 32'h70000000;
    max_lat = 3;
    build_model(20);
    tick(1'b1);
    guard = 0;
    while (!(cnt_model >= 3 && imem_req === 1'b1 && imem_rvalid) && guard < 200) begin
      tick(1'b0);
      guard++;
    end
    chk("reset_point_reached", guard < 200, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;
    clear_model();
    repeat (3) tick(1'b0);
    chk("idle_after_reset", fsm_state, 2'd0);

    // Random programs with random latency and stall.
    for (int p = 0; p < 4; p++) begin
      do_reset();
      stall_pct = 30;
      max_lat   = 3;
      gen_random_prog();
      build_model(120);
      run_prog(1'b1, cycles);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
